// File: rtl/alu_pkg.sv
// Shared opcode encodings, FSM states and request record for the ALU request front end.
package alu_pkg;

  localparam int ALU_OP_W  = 3;
  localparam int ALU_N     = 8;
  localparam int ALU_TAG_W = 4;

  localparam logic [ALU_OP_W-1:0] ALU_ADD  = 3'b000;
  localparam logic [ALU_OP_W-1:0] ALU_SUB  = 3'b001;
  localparam logic [ALU_OP_W-1:0] ALU_AND  = 3'b010;
  localparam logic [ALU_OP_W-1:0] ALU_OR   = 3'b011;
  localparam logic [ALU_OP_W-1:0] ALU_XOR  = 3'b100;
  localparam logic [ALU_OP_W-1:0] ALU_SHL  = 3'b101;
  localparam logic [ALU_OP_W-1:0] ALU_SHR  = 3'b110;
  localparam logic [ALU_OP_W-1:0] ALU_PASS = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP
  } alu_state_e;

  typedef struct packed {
    logic [ALU_N-1:0]     a;
    logic [ALU_N-1:0]     b;
    logic [ALU_OP_W-1:0]  op;
    logic [ALU_TAG_W-1:0] tag;
  } alu_req_t;

endpackage

// File: rtl/alu_req_if.sv
// Request and response valid/ready channels between a host and alu_req_ctrl.
interface alu_req_if #(
  parameter int N     = 8,
  parameter int TAG_W = 4
) ();

  logic             req_valid;
  logic             req_ready;
  logic [N-1:0]     req_a;
  logic [N-1:0]     req_b;
  logic [2:0]       req_op;
  logic [TAG_W-1:0] req_tag;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [N-1:0]     rsp_result;
  logic             rsp_carry;
  logic             rsp_zero;
  logic [TAG_W-1:0] rsp_tag;

  modport master (
    output req_valid, req_a, req_b, req_op, req_tag, rsp_ready,
    input  req_ready, rsp_valid, rsp_result, rsp_carry, rsp_zero, rsp_tag
  );

  modport slave (
    input  req_valid, req_a, req_b, req_op, req_tag, rsp_ready,
    output req_ready, rsp_valid, rsp_result, rsp_carry, rsp_zero, rsp_tag
  );

endinterface

// File: rtl/alu_req_fifo.sv
// DEPTH-entry synchronous FIFO with occupancy count; head entry is presented combinationally.
module alu_req_fifo #(
  parameter type T     = logic [7:0],
  parameter int  DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_i,
  input  T                       wdata_i,
  input  logic                   pop_i,
  output T                       rdata_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int          AW       = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  T              mem_q [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [AW:0]   count_q, count_d;
  logic          full, do_push, do_pop;

  assign full    = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    // NOTE: default assignment first, so no path leaves count_d unassigned and no latch is inferred.
    count_d = count_q;
    if (do_push && !do_pop)      count_d = count_q + (AW+1)'(1);
    else if (do_pop && !do_push) count_d = count_q - (AW+1)'(1);
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments for all state, so every register samples pre-edge values.
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + AW'(1);
      if (do_pop)  rptr_q <= rptr_q + AW'(1);
      count_q <= count_d;
    end
  end

  // NOTE: storage is deliberately not reset; count_q alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/alu_req_ctrl.sv
// Host-side ALU front end: queues requests, issues one op at a time and returns tagged results.
module alu_req_ctrl
  import alu_pkg::*;
#(
  parameter int N       = 8,
  parameter int TAG_W   = 4,
  parameter int DEPTH   = 4,
  parameter int ALU_LAT = 1
) (
  input  logic                clk,
  input  logic                rst,
  alu_req_if.slave            req_if,
  output logic [N-1:0]        alu_a,
  output logic [N-1:0]        alu_b,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                alu_en,
  input  logic [N-1:0]        alu_result,
  input  logic                alu_carry,
  input  logic                alu_zero,
  output logic [15:0]         ops_done
);

  localparam int                  CNT_W     = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
  localparam logic [CNT_W-1:0]    WCNT_LAST = CNT_W'(ALU_LAT - 1);
  localparam int                  AW        = $clog2(DEPTH);
  localparam logic [AW:0]         FULL_CNT  = (AW+1)'(DEPTH);

  typedef struct packed {
    logic [N-1:0]        a;
    logic [N-1:0]        b;
    logic [ALU_OP_W-1:0] op;
    logic [TAG_W-1:0]    tag;
  } req_t;

  req_t        push_data, head, cur_q;
  logic        fifo_empty, pop;
  logic [AW:0] fifo_count;

  alu_state_e       state_q;
  logic [CNT_W-1:0] wcnt_q;
  logic             alu_en_q, rsp_valid_q, rsp_carry_q, rsp_zero_q;
  logic [N-1:0]     rsp_result_q;
  logic [TAG_W-1:0] rsp_tag_q;
  logic [15:0]      ops_done_q;

  assign push_data = '{a: req_if.req_a, b: req_if.req_b, op: req_if.req_op, tag: req_if.req_tag};
  assign pop       = (state_q == ST_IDLE) && !fifo_empty;

  alu_req_fifo #(.T(req_t), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (req_if.req_valid),
    .wdata_i (push_data),
    .pop_i   (pop),
    .rdata_o (head),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cur_q        <= '0;
      wcnt_q       <= '0;
      alu_en_q     <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_result_q <= '0;
      rsp_carry_q  <= 1'b0;
      rsp_zero_q   <= 1'b0;
      rsp_tag_q    <= '0;
      ops_done_q   <= '0;
    end else begin
      alu_en_q <= 1'b0;
      unique case (state_q)
        // alu_en is raised on the pop edge so it is high for exactly the ISSUE cycle
        ST_IDLE: if (pop) begin
          cur_q    <= head;
          alu_en_q <= 1'b1;
          state_q  <= ST_ISSUE;
        end
        ST_ISSUE: begin
          wcnt_q  <= '0;
          state_q <= ST_WAIT;
        end
        ST_WAIT: if (wcnt_q == WCNT_LAST) begin
          rsp_result_q <= alu_result;
          rsp_carry_q  <= alu_carry;
          rsp_zero_q   <= alu_zero;
          rsp_tag_q    <= cur_q.tag;
          rsp_valid_q  <= 1'b1;
          state_q      <= ST_RESP;
        end else begin
          wcnt_q <= wcnt_q + CNT_W'(1);
        end
        ST_RESP: if (req_if.rsp_ready) begin
          rsp_valid_q <= 1'b0;
          ops_done_q  <= ops_done_q + 16'd1;
          state_q     <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign req_if.req_ready  = (fifo_count != FULL_CNT);
  assign req_if.rsp_valid  = rsp_valid_q;
  assign req_if.rsp_result = rsp_result_q;
  assign req_if.rsp_carry  = rsp_carry_q;
  assign req_if.rsp_zero   = rsp_zero_q;
  assign req_if.rsp_tag    = rsp_tag_q;

  assign alu_a    = cur_q.a;
  assign alu_b    = cur_q.b;
  assign alu_op   = cur_q.op;
  assign alu_en   = alu_en_q;
  assign ops_done = ops_done_q;

endmodule
